// File: rtl/regfile32.sv
// 32 x WIDTH register file with captured ALU flags.
// r0 reads as zero; optional same-cycle write forwarding to both read ports.
module regfile32 #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_num,
    input  logic [4:0]       rt_num,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    input  logic [4:0]       rd_num,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             wr_enable,
    input  logic [2:0]       flags_in,
    input  logic             flags_wr,
    output logic [2:0]       flags_out
);

    logic [WIDTH-1:0] regs [32];
    logic             wr_live;
    logic             fwd_rs;
    logic             fwd_rt;

    assign wr_live = wr_enable && (rd_num != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[rd_num] <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_out <= 3'b000;
        end else if (flags_wr) begin
            flags_out <= flags_in;
        end
    end

    assign fwd_rs = BYPASS && wr_live && (rd_num == rs_num);
    assign fwd_rt = BYPASS && wr_live && (rd_num == rt_num);

    // Reads are forced to zero during reset so bypass cannot leak rd_data.
    always_comb begin
        rs_data = '0;
        if (reset) begin
            if (fwd_rs) begin
                rs_data = rd_data;
            end else if (rs_num != 5'd0) begin
                rs_data = regs[rs_num];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (reset) begin
            if (fwd_rt) begin
                rt_data = rd_data;
            end else if (rt_num != 5'd0) begin
                rt_data = regs[rt_num];
            end
        end
    end

endmodule

// File: tb/tb_regfile32.sv
// Scoreboard bench for regfile32: two instances (forwarding on/off)
// driven in lockstep and compared against an array reference model.
module tb_regfile32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   rs_num, rt_num, rd_num;
    logic [W-1:0] rd_data;
    logic         wr_enable;
    logic [2:0]   flags_in;
    logic         flags_wr;

    logic [W-1:0] rs1, rt1, rs0, rt0;
    logic [2:0]   f1, f0;

    regfile32 #(.WIDTH(W), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset),
        .rs_num(rs_num), .rt_num(rt_num),
        .rs_data(rs1), .rt_data(rt1),
        .rd_num(rd_num), .rd_data(rd_data), .wr_enable(wr_enable),
        .flags_in(flags_in), .flags_wr(flags_wr), .flags_out(f1)
    );

    regfile32 #(.WIDTH(W), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset),
        .rs_num(rs_num), .rt_num(rt_num),
        .rs_data(rs0), .rt_data(rt0),
        .rd_num(rd_num), .rd_data(rd_data), .wr_enable(wr_enable),
        .flags_in(flags_in), .flags_wr(flags_wr), .flags_out(f0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a1, b1, a0, b0;
        logic [2:0]   f;
        int           tag;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] m[32];
    logic [2:0]   mf;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string name, input int tag,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input logic [4:0] idx,
                                              input bit byp);
        if (!reset) return '0;
        if (byp && wr_enable && rd_num != 0 && rd_num == idx) return rd_data;
        return m[idx];
    endfunction

    int step = 0;

    task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                         input logic [W-1:0] d, input logic [4:0] rs,
                         input logic [4:0] rt, input logic fw,
                         input logic [2:0] fin);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r; wr_enable = we; rd_num = rd; rd_data = d;
        rs_num = rs; rt_num = rt; flags_wr = fw; flags_in = fin;
        step++;
        e.a1 = model_rd(rs, 1'b1);
        e.b1 = model_rd(rt, 1'b1);
        e.a0 = model_rd(rs, 1'b0);
        e.b0 = model_rd(rt, 1'b0);
        e.f = r ? mf : 3'b000;
        e.tag = step;
        sbq.push_back(e);
        // Effect of the coming rising edge on the reference state.
        if (!r) begin
            for (int i = 0; i < 32; i++) m[i] = '0;
            mf = 3'b000;
        end else begin
            if (we && rd != 0) m[rd] = d;
            if (fw) mf = fin;
        end
    endtask

    task automatic rd2(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, 1'b0, 5'd0, '0, rs, rt, 1'b0, 3'b000);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [W-1:0] d);
        drive(1'b1, 1'b1, rd, d, 5'd0, 5'd0, 1'b0, 3'b000);
    endtask

    // Monitor: samples combinational outputs mid-cycle after each drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rs_byp", e.tag, rs1, e.a1);
                chk("rt_byp", e.tag, rt1, e.b1);
                chk("rs_nob", e.tag, rs0, e.a0);
                chk("rt_nob", e.tag, rt0, e.b0);
                chk("flags_byp", e.tag, {29'd0, f1}, {29'd0, e.f});
                chk("flags_nob", e.tag, {29'd0, f0}, {29'd0, e.f});
            end
        end
    end

    initial begin
        logic [W-1:0] a, b, diff;
        logic [2:0]   fl;
        for (int i = 0; i < 32; i++) m[i] = '0;
        mf = 3'b000;
        reset = 1'b0; wr_enable = 1'b0; rd_num = '0; rd_data = '0;
        rs_num = '0; rt_num = '0; flags_wr = 1'b0; flags_in = '0;

        drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 5'd4, 32'h1234, 5'd4, 5'd4, 1'b1, 3'b111);
        for (int i = 0; i < 32; i++) rd2(5'(i), 5'(31 - i));

        wr(5'd1, 32'd8);
        wr(5'd2, 32'd4);
        rd2(5'd1, 5'd2);
        wr(5'd0, 32'hFFFF_FFFF);
        rd2(5'd0, 5'd0);

        wr(5'd3, 32'd2);
        drive(1'b1, 1'b1, 5'd3, 32'd5, 5'd3, 5'd3, 1'b0, 3'b000);
        rd2(5'd3, 5'd3);
        drive(1'b1, 1'b1, 5'd0, 32'hABCD, 5'd0, 5'd0, 1'b0, 3'b000);

        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 3'b011);
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 3'b100);
        rd2(5'd0, 5'd0);

        for (int i = 1; i < 32; i++) wr(5'(i), W'(i));
        drive(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd31, 1'b1, 3'b111);
        rd2(5'd7, 5'd31);
        drive(1'b0, 1'b1, 5'd7, 32'd9, 5'd7, 5'd7, 1'b1, 3'b101);
        drive(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd1, 1'b0, 3'b000);

        // Write-back of an ALU subtract computed in plain arithmetic.
        wr(5'd1, 32'd2);
        wr(5'd2, 32'd5);
        rd2(5'd1, 5'd2);
        a = 32'd2; b = 32'd5;
        diff = a - b;
        fl[2] = (a[31] != b[31]) && (diff[31] != a[31]);
        fl[1] = (diff == 0);
        fl[0] = diff[31];
        drive(1'b1, 1'b1, 5'd3, diff, 5'd1, 5'd2, 1'b1, fl);
        rd2(5'd3, 5'd3);
        chk("alu_sub_value", step, m[3], 32'hFFFF_FFFD);
        chk("alu_sub_flags", step, {29'd0, mf}, {29'd0, 3'b001});

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rdn, rsn, rtn;
            rdn = 5'($urandom_range(0, 31));
            rsn = ($urandom_range(0, 3) == 0) ? rdn : 5'($urandom_range(0, 31));
            rtn = ($urandom_range(0, 3) == 0) ? rdn : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 9) < 7), rdn, $urandom,
                  rsn, rtn, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile32.md
# regfile32

32-entry x 32-bit register file with a captured-flags register, sitting directly upstream of `alu32`. Its two read ports drive the ALU's `A` and `B` operands. Its write port and flags port take the ALU's `out`, `overflow`, `zero` and `negative` back on the write-back edge. All storage is clocked on one clock and cleared by an asynchronous active-low reset.

## Interface
Parameters:
- `WIDTH`, 32: data width of every register and of all data ports.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to the matching read port. When 0, reads return stored contents only.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `rs_num`  in  5  read port A register index.
- `rt_num`  in  5  read port B register index.
- `rs_data`  out  WIDTH  read port A data; feeds ALU `A`.
- `rt_data`  out  WIDTH  read port B data; feeds ALU `B`.
- `rd_num`  in  5  write register index.
- `rd_data`  in  WIDTH  write data; the ALU `out` on write-back.
- `wr_enable`  in  1  write strobe for `rd_num`/`rd_data`.
- `flags_in`  in  3  {overflow, zero, negative} from the ALU.
- `flags_wr`  in  1  capture strobe for `flags_in`.
- `flags_out`  out  3  captured {overflow, zero, negative}.

## Operation
- Storage:
  - Registers 1..31 are WIDTH-bit state.
  - Register 0 is not storage. It always reads 0, and writes to it are discarded with no side effect.
- Reads:
  - Combinational. `rs_data` is `reg[rs_num]` and `rt_data` is `reg[rt_num]`.
  - Both ports are independent. `rs_num == rt_num` is legal, and both ports return the same value.
- Writes:
  - Occur when `wr_enable=1` at a rising `clk` with `reset=1`.
  - `reg[rd_num] <= rd_data`.
  - One write per cycle.
- Bypass (`BYPASS=1`):
  - If `wr_enable=1`, `rd_num != 0` and `rd_num == rs_num`, then `rs_data = rd_data` in the same cycle, before the edge. `rt_data` follows the same rule.
  - Bypass never applies to register 0.
  - Bypass is inactive while `reset=0`.
- Flags:
  - When `flags_wr=1` at a rising `clk`, `flags_out <= flags_in`.
  - Otherwise `flags_out` holds its value.
  - Flags have no bypass; `flags_out` reflects the new value only after the edge.
  - `flags_wr` and `wr_enable` are independent; either, both or neither may be asserted in a cycle.
- Reset:
  - `reset=0` clears registers 1..31 and `flags_out` to 0 asynchronously, without waiting for `clk`.
  - While `reset=0`:
    - all writes and flag captures are ignored;
    - `rs_data` and `rt_data` read 0 for every index;
    - `flags_out = 3'b000`.
- Undefined indices: none. All 5-bit indices are valid.

## Timing
- Read latency is 0 cycles (combinational from `rs_num`/`rt_num` and, with bypass, from `rd_data`/`wr_enable`).
- Write latency is 1 edge. Without bypass, a value written at edge N is visible on a read port immediately after edge N.
- Flags latency is 1 edge. `flags_out` updates just after the capturing edge and is stable for the following cycle.
- Reset assertion takes effect asynchronously. Reset removal is treated as synchronous to `clk`: the first write or capture happens at the first rising edge with `reset=1` after deassertion.
- Reset asserted mid-cycle while `wr_enable=1`: the pending write is lost and the target register reads 0.
- Reset values are 0 for every output: `rs_data`, `rt_data` and `flags_out`.
- Write and read of the same register in the same cycle:
  - `BYPASS=1`: the read sees the new data.
  - `BYPASS=0`: the read sees the old data before the edge and the new data after it.

## Test plan
- Reset then readback: pulse `reset=0` for 10 ns, then read all 32 indices on both ports -> every `rs_data`/`rt_data` is 0 and `flags_out=000`.
- Write/read and register 0:
  - Write 8 to r1 and 4 to r2 on consecutive edges, then `rs_num=1`, `rt_num=2` -> `rs_data=8`, `rt_data=4`.
  - Write `32'hFFFFFFFF` to r0, then read r0 -> 0.
- Bypass:
  - `BYPASS=1`, r3 holds 2. Drive `wr_enable=1`, `rd_num=3`, `rd_data=5`, `rs_num=3` -> `rs_data=5` before the edge and 5 after.
  - Same stimulus with `BYPASS=0` -> 2 before the edge, 5 after.
- Flags capture:
  - `flags_in=3'b011`, `flags_wr=1` for one edge -> `flags_out=011` after the edge.
  - Then `flags_in=3'b100` with `flags_wr=0` -> `flags_out` stays 011.
- Reset mid-operation:
  - Fill r1..r31 with the index value and set `flags_out=111`.
  - Assert `reset=0` between edges with `wr_enable=1`, `rd_num=7`, `rd_data=9` -> all reads return 0 and `flags_out=000` immediately. r7 is 0 after reset is released.
- ALU loop with `alu32`:
  - Write r1=2 and r2=5, then drive `rs_num=1`, `rt_num=2` into `alu32` with control=SUB.
  - Write back `out` to r3 and capture flags -> r3=`32'hFFFFFFFD`, `flags_out`={0,0,1}.
